// File: rtl/mem_stage_hs.sv
// Memory pipeline stage with a req/ack data-bus handshake. Aligns stores, extracts
// and extends loads, stalls upstream while waiting, and flags misaligned or timed-out accesses.
module mem_stage_hs #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_m,
    input  logic                flush_m,
    input  logic [DATA_W-1:0]   pc_plus4_m,
    input  logic                branch_link_m,
    input  logic                pc_src_m,
    input  logic                reg_write_m,
    input  logic                mem_to_reg_m,
    input  logic                mem_write_m,
    input  logic [REG_AW-1:0]   wa3_m,
    input  logic [1:0]          size_m,
    input  logic                sign_m,
    input  logic [ADDR_W-1:0]   alu_result_m,
    input  logic [DATA_W-1:0]   write_data_m,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_m,
    output logic                valid_w,
    output logic                pc_src_w,
    output logic                reg_write_w,
    output logic                mem_to_reg_w,
    output logic                branch_link_w,
    output logic [REG_AW-1:0]   wa3_w,
    output logic [ADDR_W-1:0]   alu_out_w,
    output logic [DATA_W-1:0]   read_data_w,
    output logic [DATA_W-1:0]   pc_plus4_w,
    output logic                align_err_w,
    output logic                bus_err_w
);
    localparam int NB  = DATA_W / 8;
    localparam int LB  = $clog2(NB);
    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [NB-1:0]     be;
        logic [DATA_W-1:0] wdata;
        logic [LB-1:0]     off;
        logic [1:0]        size;
        logic              sign;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic              pc_src;
        logic              reg_write;
        logic              mem_to_reg;
        logic              branch_link;
        logic [REG_AW-1:0] wa3;
        logic [ADDR_W-1:0] alu_out;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] pc_plus4;
        logic              align_err;
        logic              bus_err;
    } wreg_t;

    state_t            state_q, state_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    req_t              req_q, req_d;
    logic              flushed_q, flushed_d;
    wreg_t             w_q, w_d;

    req_t              live_req, cur_req;
    logic [LB-1:0]     off_m, lo_mask;
    logic              access_m, misalign_m, in_wait, timeout_cyc;
    logic              retire_valid, align_err_now, bus_err_now;
    logic [DATA_W-1:0] shifted, load_data;
    logic              sign_bit;
    int                nbits;

    assign off_m = alu_result_m[LB-1:0];

    // Decode the live M-side request; a size wider than the lane is always misaligned.
    always_comb begin
        access_m       = valid_m & ~flush_m & (mem_to_reg_m | mem_write_m);
        live_req.off   = off_m;
        live_req.size  = size_m;
        live_req.sign  = sign_m;
        live_req.we    = mem_write_m;
        live_req.addr  = {alu_result_m[ADDR_W-1:LB], {LB{1'b0}}};
        live_req.wdata = write_data_m << {off_m, 3'b000};
        for (int i = 0; i < LB; i++) lo_mask[i] = (i < int'(size_m));
        misalign_m = (int'(size_m) > LB) || ((off_m & lo_mask) != '0);
        for (int i = 0; i < NB; i++)
            live_req.be[i] = (i >= int'(off_m)) && (i < int'(off_m) + (1 << size_m));
    end

    // Handshake and FSM; WAIT replays the latched request while upstream is frozen.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        in_wait     = (state_q == S_WAIT);
        cur_req     = in_wait ? req_q : live_req;
        mem_req     = reset & (in_wait | (access_m & ~misalign_m));
        mem_we      = cur_req.we;
        mem_be      = cur_req.be;
        mem_addr    = cur_req.addr;
        mem_wdata   = cur_req.wdata;
        timeout_cyc = in_wait & ~mem_ack & (wcnt_q == WCNT_LAST);
        stall_m     = mem_req & ~mem_ack & ~timeout_cyc;

        state_d   = state_q;
        wcnt_d    = wcnt_q;
        req_d     = req_q;
        flushed_d = flushed_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_d   = S_WAIT;
                    wcnt_d    = WCW'(1);
                    req_d     = live_req;
                    flushed_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (mem_ack || timeout_cyc) begin
                    state_d   = S_IDLE;
                    wcnt_d    = '0;
                    flushed_d = 1'b0;
                end else begin
                    wcnt_d    = wcnt_q + 1'b1;
                    flushed_d = flushed_q | flush_m;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load extraction and the next W-register image.
    always_comb begin
        shifted = mem_rdata >> {cur_req.off, 3'b000};
        nbits   = 8 << cur_req.size;
        if (nbits > DATA_W) nbits = DATA_W;
        case (cur_req.size)
            2'd0:    sign_bit = shifted[7];
            2'd1:    sign_bit = shifted[15];
            2'd2:    sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_W-1];
        endcase
        sign_bit = sign_bit & cur_req.sign;
        for (int i = 0; i < DATA_W; i++) load_data[i] = (i < nbits) ? shifted[i] : sign_bit;

        // A flush seen at any point of a pending access turns its retirement into a bubble.
        retire_valid  = valid_m & ~flush_m & ~(in_wait & flushed_q);
        align_err_now = ~in_wait & access_m & misalign_m;
        bus_err_now   = timeout_cyc & retire_valid;

        w_d           = w_q;
        w_d.valid     = 1'b0;
        w_d.reg_write = 1'b0;
        w_d.align_err = 1'b0;
        w_d.bus_err   = 1'b0;
        if (!stall_m) begin
            w_d.valid       = retire_valid;
            w_d.reg_write   = reg_write_m & retire_valid & ~align_err_now & ~bus_err_now;
            w_d.align_err   = align_err_now;
            w_d.bus_err     = bus_err_now;
            w_d.pc_src      = pc_src_m;
            w_d.mem_to_reg  = mem_to_reg_m;
            w_d.branch_link = branch_link_m;
            w_d.wa3         = wa3_m;
            w_d.alu_out     = alu_result_m;
            w_d.read_data   = load_data;
            w_d.pc_plus4    = pc_plus4_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            req_q     <= '0;
            flushed_q <= 1'b0;
            w_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            req_q     <= req_d;
            flushed_q <= flushed_d;
            w_q       <= w_d;
        end
    end

    assign valid_w       = w_q.valid;
    assign pc_src_w      = w_q.pc_src;
    assign reg_write_w   = w_q.reg_write;
    assign mem_to_reg_w  = w_q.mem_to_reg;
    assign branch_link_w = w_q.branch_link;
    assign wa3_w         = w_q.wa3;
    assign alu_out_w     = w_q.alu_out;
    assign read_data_w   = w_q.read_data;
    assign pc_plus4_w    = w_q.pc_plus4;
    assign align_err_w   = w_q.align_err;
    assign bus_err_w     = w_q.bus_err;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized bench for mem_stage_hs: the bench plays the memory, predicts each
// retirement from plain arithmetic, and a monitor scores W-stage results from a queue.
module tb_mem_stage_hs;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int REG_AW  = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, flush_m, branch_link_m, pc_src_m, reg_write_m, mem_to_reg_m, mem_write_m;
    logic        sign_m;
    logic [31:0] pc_plus4_m, alu_result_m, write_data_m;
    logic [3:0]  wa3_m;
    logic [1:0]  size_m;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_m;
    logic        valid_w, pc_src_w, reg_write_w, mem_to_reg_w, branch_link_w, align_err_w, bus_err_w;
    logic [3:0]  wa3_w;
    logic [31:0] alu_out_w, read_data_w, pc_plus4_w;

    always #5 clk = ~clk;

    mem_stage_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .valid_m(valid_m), .flush_m(flush_m), .pc_plus4_m(pc_plus4_m),
        .branch_link_m(branch_link_m), .pc_src_m(pc_src_m), .reg_write_m(reg_write_m),
        .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m), .wa3_m(wa3_m),
        .size_m(size_m), .sign_m(sign_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_m(stall_m),
        .valid_w(valid_w), .pc_src_w(pc_src_w), .reg_write_w(reg_write_w),
        .mem_to_reg_w(mem_to_reg_w), .branch_link_w(branch_link_w), .wa3_w(wa3_w),
        .alu_out_w(alu_out_w), .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w),
        .align_err_w(align_err_w), .bus_err_w(bus_err_w)
    );

    typedef struct {
        logic        valid, flush, br, pcs, rw, ld, st, sign;
        logic [1:0]  size;
        logic [3:0]  wa3;
        logic [31:0] addr, wd, pc4;
    } instr_t;

    typedef struct {
        logic        rw, align, bus, pcs, m2r, bl, chk_rd;
        logic [3:0]  wa3;
        logic [31:0] alu, rd, pc4;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        rd_fix_en = 1'b0;
    logic [31:0] rd_fix_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
        int nb = 1 << sz;
        return (nb > 4) || ((a % nb) != 0);
    endfunction

    function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [31:0] a);
        int nb = 1 << sz;
        int off = int'(a % 4);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] wd, input logic [31:0] a);
        return wd << (8 * (a % 4));
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [1:0] sz,
                                               input logic sgn, input logic [31:0] a);
        logic [63:0] v, m;
        int nb = 1 << sz;
        v = 64'(rd) >> (8 * (a % 4));
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (sgn && v[8*nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic instr_t blank();
        instr_t in;
        in = '{valid: 1'b0, flush: 1'b0, br: 1'b0, pcs: 1'b0, rw: 1'b0, ld: 1'b0, st: 1'b0,
               sign: 1'b0, size: 2'd0, wa3: 4'd0, addr: 32'd0, wd: 32'd0, pc4: 32'd0};
        return in;
    endfunction

    task automatic apply(input instr_t in);
        valid_m = in.valid; flush_m = in.flush; pc_plus4_m = in.pc4; branch_link_m = in.br;
        pc_src_m = in.pcs; reg_write_m = in.rw; mem_to_reg_m = in.ld; mem_write_m = in.st;
        wa3_m = in.wa3; size_m = in.size; sign_m = in.sign; alu_result_m = in.addr;
        write_data_m = in.wd;
    endtask

    // Issue one instruction (called just after a rising edge); acks after 'delay' request
    // cycles, optionally pulses flush_m at request cycle 'flush_at'.
    task automatic run_instr(input instr_t in, input int delay, input int flush_at);
        logic acc, mis, req, ack, to, killed, done, valid_e;
        logic [31:0] rd;
        exp_t e;
        int k;
        apply(in);
        mem_ack = 1'b0;
        acc     = in.valid && !in.flush && (in.ld || in.st);
        mis     = acc && misaligned(in.size, in.addr);
        req     = acc && !mis;
        killed  = in.flush;
        valid_e = 1'b0;
        done    = 1'b0;
        k       = 0;
        while (!done) begin
            @(negedge clk);
            flush_m   = (k == 0) ? in.flush : (k == flush_at);
            killed    = killed | flush_m;
            ack       = req && (k == delay);
            rd        = rd_fix_en ? rd_fix_val : $urandom;
            mem_ack   = ack;
            mem_rdata = rd;
            #1;
            to = req && !ack && (k == TIMEOUT - 1);
            check("mem_req", mem_req, req);
            check("stall_m", stall_m, req && !ack && !to);
            if (req) begin
                check("mem_addr", mem_addr, in.addr & ~32'h3);
                check("mem_be", mem_be, be_model(in.size, in.addr));
                check("mem_we", mem_we, in.st);
                if (in.st) check("mem_wdata", mem_wdata, wdata_model(in.wd, in.addr));
            end
            if (!req || ack || to) begin
                done    = 1'b1;
                valid_e = in.valid && !killed;
                if (valid_e) begin
                    e.rw     = in.rw && !mis && !to;
                    e.align  = mis;
                    e.bus    = to;
                    e.pcs    = in.pcs;
                    e.m2r    = in.ld;
                    e.bl     = in.br;
                    e.wa3    = in.wa3;
                    e.alu    = in.addr;
                    e.pc4    = in.pc4;
                    e.chk_rd = in.ld && ack;
                    e.rd     = load_model(rd, in.size, in.sign, in.addr);
                    exp_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            if (!done) check("stall_valid_w", valid_w, 1'b0);
            else if (!valid_e) check("bubble_valid_w", valid_w, 1'b0);
            k++;
        end
        mem_ack = 1'b0;
        flush_m = 1'b0;
    endtask

    // Scoreboard monitor: every W-stage retirement must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && (valid_w || align_err_w || bus_err_w)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL w_retire_unexpected actual=valid_w %b align %b bus %b required=no retirement",
                         valid_w, align_err_w, bus_err_w);
            end else begin
                e = exp_q.pop_front();
                check("w_valid", valid_w, 1'b1);
                check("w_reg_write", reg_write_w, e.rw);
                check("w_align_err", align_err_w, e.align);
                check("w_bus_err", bus_err_w, e.bus);
                check("w_alu_out", alu_out_w, e.alu);
                check("w_pc_plus4", pc_plus4_w, e.pc4);
                check("w_wa3", wa3_w, e.wa3);
                check("w_pc_src", pc_src_w, e.pcs);
                check("w_mem_to_reg", mem_to_reg_w, e.m2r);
                check("w_branch_link", branch_link_w, e.bl);
                if (e.chk_rd) check("w_read_data", read_data_w, e.rd);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1);
    end

    initial begin
        instr_t in;
        int r, delay, flush_at;

        // Reset held with an aligned load presented: nothing may reach the bus or W.
        reset = 1'b0;
        apply(blank());
        mem_ack = 1'b0; mem_rdata = '0;
        valid_m = 1'b1; mem_to_reg_m = 1'b1; size_m = 2'd2; reg_write_m = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_stall_m", stall_m, 1'b0);
        check("rst_w_flags", {valid_w, reg_write_w, align_err_w, bus_err_w}, 4'b0);
        check("rst_w_data", {alu_out_w, read_data_w}, 64'd0);
        apply(blank());
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Non-memory op retires in one cycle.
        in = blank(); in.valid = 1'b1; in.rw = 1'b1; in.addr = 32'h1234; in.wa3 = 4'd3; in.pc4 = 32'h104;
        run_instr(in, 0, -1);

        // Signed byte load from the top lane, same-cycle ack.
        rd_fix_en = 1'b1; rd_fix_val = 32'h8012_3456;
        in = blank(); in.valid = 1'b1; in.rw = 1'b1; in.ld = 1'b1; in.sign = 1'b1;
        in.size = 2'd0; in.addr = 32'h1003; in.wa3 = 4'd5;
        run_instr(in, 0, -1);
        rd_fix_en = 1'b0;

        // Word store acked after three wait cycles.
        in = blank(); in.valid = 1'b1; in.st = 1'b1; in.size = 2'd2; in.addr = 32'h20; in.wd = 32'hCAFE_F00D;
        run_instr(in, 3, -1);

        // Misaligned half load, then a word load that is never acked.
        in = blank(); in.valid = 1'b1; in.rw = 1'b1; in.ld = 1'b1; in.size = 2'd1; in.addr = 32'h1001;
        run_instr(in, 0, -1);
        in = blank(); in.valid = 1'b1; in.rw = 1'b1; in.ld = 1'b1; in.size = 2'd2; in.addr = 32'h2000;
        run_instr(in, TIMEOUT + 4, -1);
        apply(blank());
        @(negedge clk);
        #1;
        check("timeout_req_dropped", mem_req, 1'b0);
        @(posedge clk);
        #1;

        // Flush pulse while waiting: the access completes on the bus but retires as a bubble.
        in = blank(); in.valid = 1'b1; in.rw = 1'b1; in.ld = 1'b1; in.size = 2'd2; in.addr = 32'h80;
        run_instr(in, 4, 2);

        // Reset asserted mid-WAIT after a retirement that left nonzero W fields.
        in = blank(); in.valid = 1'b1; in.rw = 1'b1; in.pcs = 1'b1; in.br = 1'b1;
        in.wa3 = 4'hA; in.addr = 32'hABCD; in.pc4 = 32'h44;
        run_instr(in, 0, -1);
        in = blank(); in.valid = 1'b1; in.st = 1'b1; in.size = 2'd2; in.addr = 32'h40; in.wd = 32'hDEAD_BEEF;
        apply(in);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("pre_rst_mem_req", mem_req, 1'b1);
        end
        reset = 1'b0;
        #1;
        check("midwait_rst_mem_req", mem_req, 1'b0);
        check("midwait_rst_stall", stall_m, 1'b0);
        check("midwait_rst_w_flags",
              {valid_w, pc_src_w, reg_write_w, mem_to_reg_w, branch_link_w, align_err_w, bus_err_w}, 7'd0);
        check("midwait_rst_w_fields", {wa3_w, alu_out_w, pc_plus4_w}, 68'd0);
        apply(blank());
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        in = blank(); in.valid = 1'b1; in.rw = 1'b1; in.addr = 32'h1234; in.wa3 = 4'd7;
        run_instr(in, 0, -1);

        // Randomized mix of ops, sizes, alignments, latencies, flushes and timeouts.
        for (int n = 0; n < 400; n++) begin
            in.valid = ($urandom_range(0, 9) != 0);
            in.flush = ($urandom_range(0, 11) == 0);
            r        = $urandom_range(0, 2);
            in.ld    = (r == 1);
            in.st    = (r == 2);
            in.rw    = $urandom_range(0, 1) != 0;
            in.br    = $urandom_range(0, 1) != 0;
            in.pcs   = $urandom_range(0, 1) != 0;
            in.sign  = $urandom_range(0, 1) != 0;
            r        = $urandom_range(0, 9);
            in.size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            in.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) in.addr = in.addr & ~((32'd1 << in.size) - 32'd1);
            in.wd    = $urandom;
            in.pc4   = $urandom;
            in.wa3   = 4'($urandom_range(0, 15));
            r        = $urandom_range(0, 19);
            delay    = (r == 0) ? TIMEOUT + 2 : (r < 8) ? 0 : $urandom_range(1, 5);
            flush_at = (delay >= 1 && delay < TIMEOUT && $urandom_range(0, 5) == 0)
                       ? $urandom_range(1, delay) : -1;
            run_instr(in, delay, flush_at);
        end

        apply(blank());
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
